// File: rtl/processor_pkg.sv
// Shared processor constants: instruction fields for mult/div decode,
// rstatus exception codes and the multdiv sequencer state encoding.
package processor_pkg;

    localparam logic [4:0]  OP_RTYPE     = 5'b00000;
    localparam logic [4:0]  ALU_MULT     = 5'b00110;
    localparam logic [4:0]  ALU_DIV      = 5'b00111;

    localparam logic [4:0]  REG_RSTATUS  = 5'd30;
    localparam logic [31:0] RSTATUS_MULT = 32'd4;
    localparam logic [31:0] RSTATUS_DIV  = 32'd5;

    localparam logic [1:0]  IDLE  = 2'd0;
    localparam logic [1:0]  START = 2'd1;
    localparam logic [1:0]  BUSY  = 2'd2;
    localparam logic [1:0]  DONE  = 2'd3;

    // True when the instruction word is an R-type mult or div.
    function automatic logic is_md_op(input logic [31:0] ir);
        return (ir[31:27] == OP_RTYPE) && ((ir[6:2] == ALU_MULT) || (ir[6:2] == ALU_DIV));
    endfunction

    // rstatus value written when a mult or div raises an exception.
    function automatic logic [31:0] rstatus_code(input logic is_div);
        return is_div ? RSTATUS_DIV : RSTATUS_MULT;
    endfunction

endpackage

// File: rtl/md_timeout_counter.sv
// Counts cycles spent waiting on the multdiv unit and flags the last
// permitted cycle so the sequencer can force an exception completion.
module md_timeout_counter #(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count;

    // Cycle counter: clear has priority over enable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    assign terminal = (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_sequencer.sv
// Owns all control of the shared multi-cycle multdiv unit: detects mult/div
// in DX, freezes operands, strobes the unit, stalls the front of the pipe
// and hands the result (or rstatus exception) to XM as a completed op.
module multdiv_sequencer
    import processor_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int CNT_W   = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_ir,
    input  logic        dx_valid,
    input  logic [31:0] dx_op_a,
    input  logic [31:0] dx_op_b,
    input  logic        flush,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_rdy,
    output logic [31:0] md_op_a,
    output logic [31:0] md_op_b,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [4:0]  res_rd,
    output logic        res_exception,
    output logic        busy,
    output logic        timeout_err
);

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        is_md;
    logic        start_op;
    logic        tc;
    logic        in_busy;
    logic        busy_live;

    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [4:0]  rd_q;
    logic        kind_div_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        timeout_q;

    // Only the opcode, rd and aluop fields matter here.
    logic        unused_ir_bits;
    assign unused_ir_bits = ^{dx_ir[21:7], dx_ir[1:0]};

    assign is_md     = dx_valid & is_md_op(dx_ir);
    assign start_op  = (state == IDLE) & is_md & ~flush;
    assign in_busy   = (state == BUSY);
    assign busy_live = in_busy & ~flush;

    md_timeout_counter #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .clear    (~in_busy),
        .enable   (in_busy),
        .terminal (tc)
    );

    // Next-state logic; flush aborts any in-flight op, even with md_rdy set.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_op) state_nxt = START;
            START:   state_nxt = flush ? IDLE : BUSY;
            BUSY: begin
                if (flush)             state_nxt = IDLE;
                else if (md_rdy || tc) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand/destination capture at detection; held until the next op.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_a_q     <= '0;
            op_b_q     <= '0;
            rd_q       <= '0;
            kind_div_q <= 1'b0;
        end else if (start_op) begin
            op_a_q     <= dx_op_a;
            op_b_q     <= dx_op_b;
            rd_q       <= dx_ir[26:22];
            kind_div_q <= (dx_ir[6:2] == ALU_DIV);
        end
    end

    // Result capture: unit result wins over the timeout on the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (busy_live && md_rdy) begin
            result_q <= md_result;
            exc_q    <= md_exception;
        end else if (busy_live && tc) begin
            result_q <= '0;
            exc_q    <= 1'b1;
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timeout_q <= 1'b0;
        end else if (busy_live && !md_rdy && tc) begin
            timeout_q <= 1'b1;
        end
    end

    // Output decode; the detection-cycle stall is gated so reset forces it low.
    always_comb begin
        md_op_a       = op_a_q;
        md_op_b       = op_b_q;
        ctrl_mult     = (state == START) & ~kind_div_q;
        ctrl_div      = (state == START) &  kind_div_q;
        busy          = (state == START) | (state == BUSY);
        stall         = busy | (start_op & reset);
        res_valid     = (state == DONE);
        res_exception = 1'b0;
        res_rd        = '0;
        res_data      = '0;
        if (state == DONE) begin
            res_exception = exc_q;
            res_rd        = exc_q ? REG_RSTATUS : rd_q;
            res_data      = exc_q ? rstatus_code(kind_div_q) : result_q;
        end
        timeout_err   = timeout_q;
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Randomised and directed bench for multdiv_sequencer with a cycle-level
// reference model driven from the operation schedule.
module tb_multdiv_sequencer;
    import processor_pkg::*;

    localparam int TIMEOUT = 40;

    logic        clock;
    logic        reset;
    logic [31:0] dx_ir;
    logic        dx_valid;
    logic [31:0] dx_op_a;
    logic [31:0] dx_op_b;
    logic        flush;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_rdy;
    logic [31:0] md_op_a;
    logic [31:0] md_op_b;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_rd;
    logic        res_exception;
    logic        busy;
    logic        timeout_err;

    multdiv_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
        .clock         (clock),
        .reset         (reset),
        .dx_ir         (dx_ir),
        .dx_valid      (dx_valid),
        .dx_op_a       (dx_op_a),
        .dx_op_b       (dx_op_b),
        .flush         (flush),
        .md_result     (md_result),
        .md_exception  (md_exception),
        .md_rdy        (md_rdy),
        .md_op_a       (md_op_a),
        .md_op_b       (md_op_b),
        .ctrl_mult     (ctrl_mult),
        .ctrl_div      (ctrl_div),
        .stall         (stall),
        .res_valid     (res_valid),
        .res_data      (res_data),
        .res_rd        (res_rd),
        .res_exception (res_exception),
        .busy          (busy),
        .timeout_err   (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // expected outputs for the current cycle
    logic        cmp_en = 1'b0;
    logic [31:0] exp_md_a = '0;
    logic [31:0] exp_md_b = '0;
    logic        exp_ctrl_mult = 1'b0;
    logic        exp_ctrl_div = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_busy = 1'b0;
    logic        exp_res_valid = 1'b0;
    logic [31:0] exp_res_data = '0;
    logic [4:0]  exp_res_rd = '0;
    logic        exp_res_exc = 1'b0;
    logic        exp_timeout = 1'b0;

    // observers
    int          n_mult = 0;
    int          n_div = 0;
    int          n_stall = 0;
    logic [31:0] res_log[$];
    logic [4:0]  last_rd = '0;
    logic        last_exc = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // single compare process, sampled on the falling edge
    always @(negedge clock) begin
        if (cmp_en) begin
            check32("md_op_a", md_op_a, exp_md_a);
            check32("md_op_b", md_op_b, exp_md_b);
            check32("ctrl_mult", 32'(ctrl_mult), 32'(exp_ctrl_mult));
            check32("ctrl_div", 32'(ctrl_div), 32'(exp_ctrl_div));
            check32("stall", 32'(stall), 32'(exp_stall));
            check32("busy", 32'(busy), 32'(exp_busy));
            check32("res_valid", 32'(res_valid), 32'(exp_res_valid));
            check32("timeout_err", 32'(timeout_err), 32'(exp_timeout));
            if (exp_res_valid || !reset) begin
                check32("res_data", res_data, exp_res_data);
                check32("res_rd", 32'(res_rd), 32'(exp_res_rd));
                check32("res_exception", 32'(res_exception), 32'(exp_res_exc));
            end
        end
        if (ctrl_mult) n_mult++;
        if (ctrl_div) n_div++;
        if (stall) n_stall++;
        if (res_valid) begin
            res_log.push_back(res_data);
            last_rd  = res_rd;
            last_exc = res_exception;
        end
    end

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] alu);
        logic [14:0] mid;
        mid = 15'($urandom);
        return {op, rd, mid, alu, 2'b00};
    endfunction

    task automatic exp_idle();
        exp_ctrl_mult = 1'b0;
        exp_ctrl_div  = 1'b0;
        exp_stall     = 1'b0;
        exp_busy      = 1'b0;
        exp_res_valid = 1'b0;
        exp_res_data  = '0;
        exp_res_rd    = '0;
        exp_res_exc   = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One op from detection. k: BUSY cycle on which md_rdy rises (never if
    // > TIMEOUT); f: flush cycle (0 = START, n = n-th BUSY cycle, <0 none).
    task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int k, input int f, input bit exc);
        logic [31:0] ir;
        logic [31:0] result;
        int          j;
        bit          timed_out;
        result = is_div ? ((b == 0) ? 32'd0 : a / b) : a * b;
        ir = mk_ir(OP_RTYPE, rd, is_div ? ALU_DIV : ALU_MULT);
        // detection cycle
        dx_ir = ir; dx_valid = 1'b1; dx_op_a = a; dx_op_b = b; flush = 1'b0;
        md_rdy = 1'($urandom); md_result = $urandom; md_exception = 1'($urandom);
        exp_idle();
        exp_stall = 1'b1;
        step();
        // start strobe; bypassed operands change but the unit must see a/b
        dx_op_a = $urandom; dx_op_b = $urandom;
        md_rdy = 1'($urandom); md_exception = 1'($urandom);
        flush = (f == 0);
        exp_ctrl_mult = !is_div; exp_ctrl_div = is_div;
        exp_stall = 1'b1; exp_busy = 1'b1;
        exp_md_a = a; exp_md_b = b;
        step();
        if (f == 0) begin
            flush = 1'b0; dx_valid = 1'b0; md_rdy = 1'b0;
            exp_idle();
            return;
        end
        exp_ctrl_mult = 1'b0; exp_ctrl_div = 1'b0;
        j = 1;
        while (1) begin
            md_rdy       = (j == k);
            md_result    = (j == k && !exc) ? result : $urandom;
            md_exception = (j == k) ? exc : 1'($urandom);
            flush        = (j == f);
            dx_op_a = $urandom; dx_op_b = $urandom;
            step();
            if (j == f) begin
                flush = 1'b0; dx_valid = 1'b0; md_rdy = 1'b0;
                exp_idle();
                return;
            end
            if (j == k || j >= TIMEOUT) break;
            j++;
        end
        timed_out = (j != k);
        // completion cycle; DX still shows the op but it must not restart
        flush = 1'b0; md_rdy = 1'($urandom); md_result = $urandom;
        exp_stall = 1'b0; exp_busy = 1'b0; exp_res_valid = 1'b1;
        if (timed_out || exc) begin
            exp_res_exc  = 1'b1;
            exp_res_rd   = REG_RSTATUS;
            exp_res_data = is_div ? 32'd5 : 32'd4;
        end else begin
            exp_res_exc  = 1'b0;
            exp_res_rd   = rd;
            exp_res_data = result;
        end
        if (timed_out) exp_timeout = 1'b1;
        step();
        dx_valid = 1'b0; md_rdy = 1'b0;
        exp_idle();
    endtask

    // Idle cycles with traffic that must never start an op.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: begin dx_ir = mk_ir(OP_RTYPE, 5'($urandom), 5'b00000); dx_valid = 1'b1; flush = 1'($urandom); end
                1: begin dx_ir = mk_ir(OP_RTYPE, 5'($urandom), ALU_MULT); dx_valid = 1'b1; flush = 1'b1; end
                2: begin dx_ir = mk_ir(5'b00101, 5'($urandom), ALU_DIV); dx_valid = 1'b1; flush = 1'b0; end
                default: begin dx_ir = mk_ir(OP_RTYPE, 5'($urandom), ALU_DIV); dx_valid = 1'b0; flush = 1'b0; end
            endcase
            dx_op_a = $urandom; dx_op_b = $urandom;
            md_rdy = 1'($urandom); md_result = $urandom; md_exception = 1'($urandom);
            exp_idle();
            step();
        end
        dx_valid = 1'b0; flush = 1'b0; md_rdy = 1'b0;
    endtask

    initial begin
        int base_m, base_d, base_s, base_r;
        reset = 1'b0; dx_ir = '0; dx_valid = 1'b0; dx_op_a = '0; dx_op_b = '0;
        flush = 1'b0; md_result = '0; md_exception = 1'b0; md_rdy = 1'b0;
        #12;
        check32("rst_stall", 32'(stall), 32'd0);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_res_valid", 32'(res_valid), 32'd0);
        check32("rst_md_op_a", md_op_a, 32'd0);
        check32("rst_timeout", 32'(timeout_err), 32'd0);
        reset = 1'b1;
        cmp_en = 1'b1;
        step();

        // mult 3*7 -> r5, md_rdy 17 cycles after the strobe
        base_m = n_mult; base_s = n_stall; base_r = res_log.size();
        run_op(1'b0, 32'd3, 32'd7, 5'd5, 17, -1, 1'b0);
        check32("t1_strobes", 32'(n_mult - base_m), 32'd1);
        check32("t1_stall_cycles", 32'(n_stall - base_s), 32'd19);
        check32("t1_res_pulses", 32'(res_log.size() - base_r), 32'd1);
        check32("t1_res_data", res_log[res_log.size() - 1], 32'd21);
        check32("t1_res_rd", 32'(last_rd), 32'd5);
        idle_cycles(2);

        // div 10/0 -> exception
        base_d = n_div;
        run_op(1'b1, 32'd10, 32'd0, 5'd9, 6, -1, 1'b1);
        check32("t2_strobes", 32'(n_div - base_d), 32'd1);
        check32("t2_res_data", res_log[res_log.size() - 1], 32'd5);
        check32("t2_res_rd", 32'(last_rd), 32'd30);
        check32("t2_res_exc", 32'(last_exc), 32'd1);
        idle_cycles(2);

        // flush together with md_rdy on the 4th BUSY cycle
        base_r = res_log.size();
        run_op(1'b0, 32'd6, 32'd9, 5'd12, 4, 4, 1'b0);
        idle_cycles(1);
        check32("t3_res_pulses", 32'(res_log.size() - base_r), 32'd0);

        // timeout
        run_op(1'b0, 32'd5, 32'd5, 5'd7, 1000, -1, 1'b0);
        check32("t4_res_data", res_log[res_log.size() - 1], 32'd4);
        check32("t4_res_rd", 32'(last_rd), 32'd30);
        idle_cycles(3);
        check32("t4_timeout_sticky", 32'(timeout_err), 32'd1);

        // back-to-back mult then div
        base_r = res_log.size(); base_m = n_mult; base_d = n_div;
        run_op(1'b0, 32'd8, 32'd3, 5'd2, 3, -1, 1'b0);
        run_op(1'b1, 32'd100, 32'd7, 5'd4, 9, -1, 1'b0);
        check32("t5_res_pulses", 32'(res_log.size() - base_r), 32'd2);
        check32("t5_first", res_log[base_r], 32'd24);
        check32("t5_second", res_log[base_r + 1], 32'd14);
        check32("t5_strobes", 32'((n_mult - base_m) + (n_div - base_d)), 32'd2);
        idle_cycles(1);

        // randomised ops
        for (int n = 0; n < 60; n++) begin
            bit          d;
            logic [31:0] a, b;
            int          k, f;
            bit          e;
            d = 1'($urandom);
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom_range(1, 1000);
            k = $urandom_range(1, 50);
            f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 10) : -1;
            e = d ? (b == 0) : ($urandom_range(0, 7) == 0);
            run_op(d, a, b, 5'($urandom), k, f, e);
            if ($urandom_range(0, 2) != 0) idle_cycles($urandom_range(1, 2));
        end

        // reset mid-BUSY
        cmp_en = 1'b0;
        dx_ir = mk_ir(OP_RTYPE, 5'd3, ALU_MULT); dx_valid = 1'b1;
        dx_op_a = 32'd11; dx_op_b = 32'd13; flush = 1'b0; md_rdy = 1'b0;
        repeat (5) step();
        #2;
        reset = 1'b0;
        #1;
        check32("arst_busy", 32'(busy), 32'd0);
        check32("arst_stall", 32'(stall), 32'd0);
        check32("arst_md_op_a", md_op_a, 32'd0);
        check32("arst_ctrl", 32'(ctrl_mult | ctrl_div), 32'd0);
        check32("arst_res_valid", 32'(res_valid), 32'd0);
        check32("arst_timeout", 32'(timeout_err), 32'd0);
        exp_idle(); exp_md_a = '0; exp_md_b = '0; exp_timeout = 1'b0;
        cmp_en = 1'b1;
        step();
        md_rdy = 1'b1; md_result = 32'hdead_beef;
        step();
        reset = 1'b1; dx_valid = 1'b0; md_rdy = 1'b0;
        step();
        base_r = res_log.size();
        run_op(1'b0, 32'd4, 32'd6, 5'd17, 5, -1, 1'b0);
        check32("t6_res_pulses", 32'(res_log.size() - base_r), 32'd1);
        check32("t6_res_data", res_log[res_log.size() - 1], 32'd24);
        check32("t6_res_rd", 32'(last_rd), 32'd17);
        idle_cycles(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
